clk_enable_gen: RTL

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

---
 rtl/clk_enable_gen.sv | 89 ++++++++
 1 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: each channel divides clkIn by a
// runtime-loadable divisor and emits a one-cycle tick plus a square wave.
module clk_enable_gen #(
    parameter int                          NUM_CH   = 2,
    parameter int                          CNT_W    = 24,
    parameter logic [NUM_CH*CNT_W-1:0]     DIV_INIT = {24'd4, 24'd1_000_000}
) (
    input  logic                  clkIn,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync,
    input  logic [NUM_CH-1:0]     divLoad,
    input  logic [CNT_W-1:0]      divIn,
    output logic [NUM_CH-1:0]     tick,
    output logic [NUM_CH-1:0]     clkOut
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // A zero divisor is meaningless, so a load strobe carrying zero is dropped.
    logic w_div_in_valid;
    assign w_div_in_valid = (divIn != CNT_ZERO);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_cnt;
        logic             r_tick;
        logic             r_clk;

        logic             w_load;
        logic             w_wrap;
        logic [CNT_W-1:0] w_cnt_inc;
        logic [CNT_W-1:0] w_div_nxt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_tick_nxt;
        logic             w_clk_nxt;

        assign w_load = divLoad[g] && w_div_in_valid;

        // Next-state selection: load/sync restart the phase, en advances it.
        always_comb begin
            w_wrap     = (r_cnt == (r_div - CNT_ONE));
            w_cnt_inc  = w_wrap ? CNT_ZERO : (r_cnt + CNT_ONE);
            w_div_nxt  = r_div;
            w_cnt_nxt  = r_cnt;
            w_tick_nxt = 1'b0;
            w_clk_nxt  = r_clk;
            if (w_load) begin
                w_div_nxt  = divIn;
                w_cnt_nxt  = CNT_ZERO;
                w_tick_nxt = 1'b0;
                w_clk_nxt  = 1'b0;
            end else if (sync) begin
                w_cnt_nxt  = CNT_ZERO;
                w_tick_nxt = 1'b0;
                w_clk_nxt  = 1'b0;
            end else if (en) begin
                w_cnt_nxt  = w_cnt_inc;
                w_tick_nxt = w_wrap;
                // High for the upper ceil(div/2) counts of each period.
                w_clk_nxt  = (w_cnt_inc >= (r_div >> 1));
            end else begin
                w_cnt_nxt  = r_cnt;
                w_tick_nxt = 1'b0;
                w_clk_nxt  = r_clk;
            end
        end

        // Channel state registers with asynchronous reset to the init divisor.
        always_ff @(posedge clkIn or posedge rst) begin
            if (rst) begin
                r_div  <= DIV_INIT[g*CNT_W +: CNT_W];
                r_cnt  <= CNT_ZERO;
                r_tick <= 1'b0;
                r_clk  <= 1'b0;
            end else begin
                r_div  <= w_div_nxt;
                r_cnt  <= w_cnt_nxt;
                r_tick <= w_tick_nxt;
                r_clk  <= w_clk_nxt;
            end
        end

        assign tick[g]   = r_tick;
        assign clkOut[g] = r_clk;
    end

endmodule
